// File: rtl/neuro_pkg.sv
// Shared constants and types for the neuro accelerator blocks.
package neuro_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    localparam logic [7:0] END_OF_PROGRAM = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FINISH
    } state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with full/empty/count status and a combinational head.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/result_unloader.sv
// Streams the accelerator's result words from neuron RAM to the host as bytes.
// Optional argmax tracking is enabled with `define RESULT_UNLOADER_ARGMAX_EN.
module result_unloader #(
    parameter int DATA_W     = neuro_pkg::DATA_W,
    parameter int ADDR_W     = neuro_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_finished,
    input  logic [ADDR_W-1:0] result_base_address,
    input  logic [ADDR_W-1:0] result_word_count,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef RESULT_UNLOADER_ARGMAX_EN
    ,
    output logic [ADDR_W-1:0] argmax_idx,
    output logic              argmax_valid
`endif
);

    import neuro_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    state_t            state;
    state_t            next_state;
    logic              prev_fin;
    logic              trigger;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] remaining_rd;
    logic [ADDR_W-1:0] remaining_out;
    logic              rd_pending;
    logic              handshake;
    logic              has_space;
    logic [OCC_W-1:0]  occupancy;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign trigger   = acc_finished && !prev_fin && (state == IDLE);
    assign handshake = out_valid && out_ready;

    // A read still in flight already owns a FIFO slot.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending};
    assign has_space = !fifo_full && (occupancy < OCC_W'(FIFO_DEPTH));

    assign out_valid   = !fifo_empty;
    assign out_data    = out_valid ? fifo_head : '0;
    assign out_last    = out_valid && (remaining_out == ADDR_W'(1));
    assign ram_rd_addr = rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block is defaulted first, so no path leaves a latch behind.
    always_comb begin
        next_state = state;
        ram_rd_en  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) next_state = (result_word_count == '0) ? FINISH : STREAM;
            end
            STREAM: begin
                busy      = 1'b1;
                ram_rd_en = (remaining_rd != '0) && has_space;
                if (handshake && remaining_out == ADDR_W'(1)) next_state = FINISH;
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_fin      <= 1'b0;
            rd_ptr        <= '0;
            remaining_rd  <= '0;
            remaining_out <= '0;
            rd_pending    <= 1'b0;
        end else begin
            prev_fin   <= acc_finished;
            rd_pending <= ram_rd_en;
            if (trigger) begin
                rd_ptr        <= result_base_address;
                remaining_rd  <= result_word_count;
                remaining_out <= result_word_count;
            end else begin
                if (ram_rd_en) begin
                    rd_ptr       <= rd_ptr + 1'b1;
                    remaining_rd <= remaining_rd - 1'b1;
                end
                if (handshake) remaining_out <= remaining_out - 1'b1;
            end
        end
    end

    // Clearing rd_pending on reset drops any RAM data still returning.
    result_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rd_pending),
        .wr_data (ram_rd_data),
        .rd_en   (handshake),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef RESULT_UNLOADER_ARGMAX_EN
    logic signed [DATA_W-1:0] best_val;
    logic        [ADDR_W-1:0] beat_idx;

    // Strictly greater keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            argmax_idx <= '0;
            best_val   <= '0;
            beat_idx   <= '0;
        end else if (trigger) begin
            argmax_idx <= '0;
            beat_idx   <= '0;
        end else if (handshake) begin
            beat_idx <= beat_idx + 1'b1;
            if (beat_idx == '0 || $signed(out_data) > best_val) begin
                best_val   <= out_data;
                argmax_idx <= beat_idx;
            end
        end
    end

    assign argmax_valid = done;
`endif

endmodule

// File: tb/tb_result_unloader.sv
// Scoreboard bench for result_unloader: stimulus pushes expectations, a monitor pops and compares.
module tb_result_unloader;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       acc_finished;
    logic [7:0] result_base_address;
    logic [7:0] result_word_count;
    logic       ram_rd_en;
    logic [7:0] ram_rd_addr;
    logic [7:0] ram_rd_data = '0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       done;
`ifdef RESULT_UNLOADER_ARGMAX_EN
    logic [7:0] argmax_idx;
    logic       argmax_valid;
    logic [7:0] argmax_at_done;
`endif

    result_unloader #(
        .DATA_W     (8),
        .ADDR_W     (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .acc_finished        (acc_finished),
        .result_base_address (result_base_address),
        .result_word_count   (result_word_count),
        .ram_rd_en           (ram_rd_en),
        .ram_rd_addr         (ram_rd_addr),
        .ram_rd_data         (ram_rd_data),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .out_last            (out_last),
        .out_ready           (out_ready),
        .busy                (busy),
        .done                (done)
`ifdef RESULT_UNLOADER_ARGMAX_EN
        ,
        .argmax_idx          (argmax_idx),
        .argmax_valid        (argmax_valid)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Neuron RAM model: data valid one cycle after the strobe.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    bit ready_pat[$];
    int ready_idx = 0;
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = (ready_pat.size() == 0) ? 1'b1 : ready_pat[ready_idx % ready_pat.size()];
        ready_idx++;
    end

    logic [8:0] exp_beats[$];
    logic [7:0] exp_addrs[$];
    int         first_rd_cyc    = -1;
    int         first_valid_cyc = -1;
    int         last_hs_cyc     = -1;
    int         done_cyc        = -1;
    int         done_count      = 0;
    int         reads_issued    = 0;
    int         beats_accepted  = 0;
    int         t_trig          = 0;
    bit         busy_seen       = 0;
    bit         stalled         = 0;
    logic [7:0] held_data       = '0;
    logic       held_last       = 1'b0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            stalled = 0;
        end else begin
            if (busy) busy_seen = 1;
            if (ram_rd_en) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                check("rd_outstanding", 32'((reads_issued - beats_accepted) < DEPTH), 1);
                check("rd_expected", 32'(exp_addrs.size() != 0), 1);
                if (exp_addrs.size() != 0) check("rd_addr", ram_rd_addr, exp_addrs.pop_front());
                reads_issued++;
            end
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_data);
                check("stall_last", out_last, held_last);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                check("beat_expected", 32'(exp_beats.size() != 0), 1);
                if (exp_beats.size() != 0) begin
                    logic [8:0] e;
                    e = exp_beats.pop_front();
                    check("beat_data", out_data, e[7:0]);
                    check("beat_last", out_last, e[8]);
                end
                beats_accepted++;
                last_hs_cyc = cyc;
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (done) begin
                done_count++;
                done_cyc = cyc;
`ifdef RESULT_UNLOADER_ARGMAX_EN
                argmax_at_done = argmax_idx;
`endif
            end
`ifdef RESULT_UNLOADER_ARGMAX_EN
            if (argmax_valid || done) check("argmax_valid_with_done", argmax_valid, done);
`endif
        end
    end

    task automatic arm_expect(input logic [7:0] base_a, input logic [7:0] vals[$]);
        exp_beats.delete();
        exp_addrs.delete();
        foreach (vals[i]) begin
            exp_beats.push_back({i == vals.size() - 1, vals[i]});
            exp_addrs.push_back(base_a + 8'(i));
        end
        reads_issued    = 0;
        beats_accepted  = 0;
        first_rd_cyc    = -1;
        first_valid_cyc = -1;
        last_hs_cyc     = -1;
        busy_seen       = 0;
        ready_idx       = 0;
        t_trig          = cyc;
    endtask

    // Loads RAM, raises acc_finished and scrambles the address inputs one cycle later.
    task automatic start_unload(input logic [7:0] base_a, input logic [7:0] vals[$]);
        foreach (vals[i]) ram[base_a + 8'(i)] = vals[i];
        @(posedge clk);
        #1;
        arm_expect(base_a, vals);
        result_base_address = base_a;
        result_word_count   = 8'(vals.size());
        acc_finished        = 1'b1;
        @(posedge clk);
        #1;
        result_base_address = 8'h33;
        result_word_count   = 8'h07;
    endtask

    task automatic finish_unload(input string name, input int count, input int d0, input int exp_argmax);
        int budget = 300;
        while (done_count == d0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check({name, "_done_seen"}, 32'(done_count == d0 + 1), 1);
        if (count == 0) begin
            check({name, "_no_read"}, first_rd_cyc, -1);
            check({name, "_no_valid"}, first_valid_cyc, -1);
            check({name, "_busy_never"}, 32'(busy_seen), 0);
            check({name, "_done_cycle"}, done_cyc, t_trig + 1);
        end else begin
            check({name, "_first_read"}, first_rd_cyc, t_trig + 1);
            check({name, "_beats"}, beats_accepted, count);
            check({name, "_done_after_last"}, done_cyc, last_hs_cyc + 1);
        end
`ifdef RESULT_UNLOADER_ARGMAX_EN
        check({name, "_argmax"}, argmax_at_done, exp_argmax);
`else
        if (exp_argmax < 0) $display("note: negative argmax expectation ignored");
`endif
        repeat (3) @(posedge clk);
        #1;
        check({name, "_no_retrigger"}, busy, 0);
        check({name, "_single_done"}, done_count, d0 + 1);
        acc_finished = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_beats_drained"}, exp_beats.size(), 0);
        check({name, "_reads_drained"}, exp_addrs.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v[$];
        int         d0;
        int         budget;

        reset               = 1'b1;
        acc_finished        = 1'b0;
        result_base_address = '0;
        result_word_count   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_rd_addr", ram_rd_addr, 0);
`ifdef RESULT_UNLOADER_ARGMAX_EN
        check("rst_argmax_idx", argmax_idx, 0);
        check("rst_argmax_valid", argmax_valid, 0);
`endif

        // Base 20, three words, host always ready.
        v = '{8'd5, 8'hFD, 8'd7};
        d0 = done_count;
        start_unload(8'd20, v);
        finish_unload("basic", 3, d0, 2);
        check("basic_latency", first_valid_cyc - t_trig, 3);

        // Same data under a stalling host.
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        d0 = done_count;
        start_unload(8'd20, v);
        finish_unload("stall", 3, d0, 2);
        ready_pat.delete();

        // Zero-length result.
        v.delete();
        d0 = done_count;
        start_unload(8'd40, v);
        finish_unload("count0", 0, d0, 0);

        // Address wrap 254, 255, 0, 1.
        v = '{8'h11, 8'h22, 8'h33, 8'h44};
        d0 = done_count;
        start_unload(8'd254, v);
        finish_unload("wrap", 4, d0, 3);

        // Reset after two of five beats; still-high acc_finished must retrigger.
        v = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
        d0 = done_count;
        start_unload(8'd100, v);
        result_base_address = 8'd100;
        result_word_count   = 8'd5;
        budget = 50;
        while (beats_accepted < 2 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("rst_mid_two_beats", beats_accepted, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        arm_expect(8'd100, v);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_no_done_count", done_count, d0);
        finish_unload("rst_restart", 5, d0, 4);

`ifdef RESULT_UNLOADER_ARGMAX_EN
        v = '{8'd9, 8'd9, 8'd1};
        d0 = done_count;
        start_unload(8'd60, v);
        finish_unload("argmax_tie", 3, d0, 0);

        v = '{8'h80, 8'h01};
        d0 = done_count;
        start_unload(8'd70, v);
        finish_unload("argmax_signed", 2, d0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
